// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command master: opcodes, command encodings,
// serializer states and frame-layout helpers.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CmdWr     = 2'b00,
    CmdRd     = 2'b01,
    CmdAluOp  = 2'b10,
    CmdAluNop = 2'b11
  } cmd_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } ser_state_e;

  function automatic logic [2:0] byte_count(input cmd_type_e t);
    logic [2:0] n;
    unique case (t)
      CmdWr:    n = 3'd3;
      CmdAluOp: n = 3'd4;
      default:  n = 3'd2;
    endcase
    return n;
  endfunction

  // Byte at position idx within the frame sequence of a command.
  function automatic logic [7:0] frame_byte(input cmd_type_e t, input logic [1:0] idx,
                                            input logic [7:0] addr, input logic [7:0] data,
                                            input logic [7:0] op_a, input logic [7:0] op_b,
                                            input logic [7:0] func);
    logic [7:0] b;
    unique case (t)
      CmdWr: begin
        unique case (idx)
          2'd0:    b = CMD_WR;
          2'd1:    b = addr;
          default: b = data;
        endcase
      end
      CmdRd:    b = (idx == 2'd0) ? CMD_RD : addr;
      CmdAluOp: begin
        unique case (idx)
          2'd0:    b = CMD_ALU_OP;
          2'd1:    b = op_a;
          2'd2:    b = op_b;
          default: b = func;
        endcase
      end
      default:  b = (idx == 2'd0) ? CMD_ALU_NOP : func;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_master_ser.sv
// UART byte serializer: start, 8 data bits LSB first, parity, stop; registered line output.
module uart_frame_ser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned PRESCALE = 8,
  parameter bit          PAR_ODD  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data_in,
  output logic       tx_out,
  output logic       byte_done
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  ser_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d, bit_nxt;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;
  logic            wrap;

  assign wrap      = (cnt_q == CntW'(PRESCALE - 1));
  assign bit_nxt   = bit_idx_q + 3'd1;
  assign tx_out    = tx_q;
  assign byte_done = (state_q == StStop) && wrap;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    tx_d      = tx_q;
    if (state_q != StIdle) cnt_d = wrap ? '0 : cnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StStart;
          cnt_d   = '0;
          data_d  = data_in;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (wrap) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
          tx_d      = data_q[0];
        end
      end
      StData: begin
        if (wrap) begin
          if (bit_idx_q == 3'd7) begin
            state_d = StParity;
            tx_d    = ^data_q ^ PAR_ODD;
          end else begin
            bit_idx_d = bit_nxt;
            tx_d      = data_q[bit_nxt];
          end
        end
      end
      StParity: begin
        if (wrap) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        // Next byte of the same command starts with no idle gap.
        if (wrap) begin
          if (load) begin
            state_d = StStart;
            data_d  = data_in;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/uart_cmd_master.sv
// Host-side UART command initiator: captures one command and sends its 2-4 byte frame sequence.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int unsigned PRESCALE = 8,
  parameter bit          PAR_ODD  = 1'b1
) (
  input  logic       UART_clck,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic [7:0] cmd_op_a,
  input  logic [7:0] cmd_op_b,
  input  logic [7:0] cmd_func,
  output logic       tx_out,
  output logic       byte_done,
  output logic       cmd_done
);

  cmd_type_e  type_q;
  logic [7:0] addr_q, data_q, op_a_q, op_b_q, func_q;
  logic       busy_q, busy_d;
  logic [1:0] idx_q, idx_d, idx_nxt;
  logic       cmd_done_q, cmd_done_d;
  logic       accept, last_byte, ser_load;
  logic [7:0] ser_byte;

  assign cmd_ready = !busy_q;
  assign cmd_done  = cmd_done_q;
  assign accept    = cmd_valid && cmd_ready;
  assign idx_nxt   = idx_q + 2'd1;
  assign last_byte = ({1'b0, idx_q} == byte_count(type_q) - 3'd1);

  always_comb begin
    busy_d     = busy_q;
    idx_d      = idx_q;
    cmd_done_d = 1'b0;
    ser_load   = 1'b0;
    ser_byte   = frame_byte(type_q, idx_nxt, addr_q, data_q, op_a_q, op_b_q, func_q);
    if (accept) begin
      // First byte comes straight from the inputs so the start bit begins at acceptance.
      busy_d   = 1'b1;
      idx_d    = 2'd0;
      ser_load = 1'b1;
      ser_byte = frame_byte(cmd_type_e'(cmd_type), 2'd0, cmd_addr, cmd_data, cmd_op_a,
                            cmd_op_b, cmd_func);
    end else if (busy_q && byte_done) begin
      if (last_byte) begin
        busy_d     = 1'b0;
        cmd_done_d = 1'b1;
      end else begin
        idx_d    = idx_nxt;
        ser_load = 1'b1;
      end
    end
  end

  always_ff @(posedge UART_clck or negedge rst) begin
    if (!rst) begin
      busy_q     <= 1'b0;
      idx_q      <= 2'd0;
      cmd_done_q <= 1'b0;
      type_q     <= CmdWr;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      op_a_q     <= 8'h00;
      op_b_q     <= 8'h00;
      func_q     <= 8'h00;
    end else begin
      busy_q     <= busy_d;
      idx_q      <= idx_d;
      cmd_done_q <= cmd_done_d;
      if (accept) begin
        type_q <= cmd_type_e'(cmd_type);
        addr_q <= cmd_addr;
        data_q <= cmd_data;
        op_a_q <= cmd_op_a;
        op_b_q <= cmd_op_b;
        func_q <= cmd_func;
      end
    end
  end

  uart_frame_ser #(
    .PRESCALE (PRESCALE),
    .PAR_ODD  (PAR_ODD)
  ) u_ser (
    .clk       (UART_clck),
    .rst       (rst),
    .load      (ser_load),
    .data_in   (ser_byte),
    .tx_out    (tx_out),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_uart_cmd_master.sv
// Scoreboarded bench for uart_cmd_master: expected bytes queued at issue, line decoded per cycle.
`timescale 1ns/1ps
module tb_uart_cmd_master;

  localparam int unsigned P        = 8;
  localparam bit          PAR      = 1'b1;
  localparam int          BYTE_CYC = 11 * P;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_type = 2'b00;
  logic [7:0] cmd_addr = 8'h00, cmd_data = 8'h00, cmd_op_a = 8'h00;
  logic [7:0] cmd_op_b = 8'h00, cmd_func = 8'h00;
  logic       cmd_ready, tx_out, byte_done, cmd_done;

  int n_checks = 0;
  int n_pass = 0;
  int done_pulses = 0;
  logic [7:0] exp_q[$];

  logic [7:0]  mon_byte;
  logic [10:0] mon_bits;
  bit          mon_abort;

  uart_cmd_master #(
    .PRESCALE (P),
    .PAR_ODD  (PAR)
  ) dut (
    .UART_clck (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_op_a  (cmd_op_a),
    .cmd_op_b  (cmd_op_b),
    .cmd_func  (cmd_func),
    .tx_out    (tx_out),
    .byte_done (byte_done),
    .cmd_done  (cmd_done)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) if (cmd_done) done_pulses <= done_pulses + 1;

  // Line monitor: every cycle of a frame is compared against the bit the popped byte implies.
  initial begin : line_monitor
    forever begin
      @(negedge clk);
      if (rst && tx_out == 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          repeat (BYTE_CYC - 1) @(negedge clk);
        end else begin
          mon_byte  = exp_q.pop_front();
          mon_bits  = {1'b1, ^mon_byte ^ PAR, mon_byte, 1'b0};
          mon_abort = 1'b0;
          for (int i = 0; i < BYTE_CYC && !mon_abort; i++) begin
            if (i > 0) @(negedge clk);
            if (!rst) mon_abort = 1'b1;
            else check("line", {31'd0, tx_out}, {31'd0, mon_bits[i / P]});
          end
        end
      end
    end
  end

  task automatic run_cmd(input logic [1:0] t, input logic [7:0] addr, input logic [7:0] data,
                         input logic [7:0] op_a, input logic [7:0] op_b,
                         input logic [7:0] func, input bit noise, input int abort_at);
    int n, cyc, ready_low, bd, waited, bad_done, bad_tx, bad_bd;
    bit got_done;
    n = (t == 2'b00) ? 3 : (t == 2'b10) ? 4 : 2;
    cmd_type = t; cmd_addr = addr; cmd_data = data;
    cmd_op_a = op_a; cmd_op_b = op_b; cmd_func = func;
    cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    case (t)
      2'b00: begin exp_q.push_back(8'hAA); exp_q.push_back(addr); exp_q.push_back(data); end
      2'b01: begin exp_q.push_back(8'hBB); exp_q.push_back(addr); end
      2'b10: begin
        exp_q.push_back(8'hCC); exp_q.push_back(op_a);
        exp_q.push_back(op_b);  exp_q.push_back(func);
      end
      default: begin exp_q.push_back(8'hDD); exp_q.push_back(func); end
    endcase
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    check("start_bit", {31'd0, tx_out}, 32'd0);
    ready_low = 0; bd = 0; got_done = 1'b0;
    while (1) begin
      if (cmd_done) begin
        got_done = 1'b1;
        break;
      end
      if (!cmd_ready) ready_low++;
      if (byte_done) bd++;
      if (abort_at != 0 && cyc == abort_at) begin
        check("pre_reset_tx", {31'd0, tx_out}, 32'd0);
        rst = 1'b0;
        #1;
        check("reset_tx_async", {31'd0, tx_out}, 32'd1);
        check("reset_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst = 1'b1;
        bad_done = 0; bad_tx = 0; bad_bd = 0;
        repeat (40) begin
          @(negedge clk);
          if (cmd_done) bad_done++;
          if (!tx_out) bad_tx++;
          if (byte_done) bad_bd++;
        end
        check("no_done_after_reset", bad_done, 0);
        check("idle_after_reset", bad_tx, 0);
        check("no_byte_done_after_reset", bad_bd, 0);
        check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
        return;
      end
      if (noise && cyc < n * BYTE_CYC - 4) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_type  = 2'($urandom_range(0, 3));
        cmd_addr  = 8'($urandom_range(0, 255));
        cmd_data  = 8'($urandom_range(0, 255));
        cmd_op_a  = 8'($urandom_range(0, 255));
        cmd_op_b  = 8'($urandom_range(0, 255));
        cmd_func  = 8'($urandom_range(0, 255));
      end else begin
        cmd_valid = 1'b0;
      end
      if (cyc >= n * BYTE_CYC + 20) break;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", {31'd0, got_done}, 32'd1);
    check("done_cycle", cyc, n * BYTE_CYC + 1);
    check("ready_low_cycles", ready_low, n * BYTE_CYC);
    check("byte_done_count", bd, n);
    check("done_ready", {31'd0, cmd_ready}, 32'd1);
    check("done_tx_idle", {31'd0, tx_out}, 32'd1);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx_out}, 32'd1);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_byte_done", {31'd0, byte_done}, 32'd0);
    check("rst_cmd_done", {31'd0, cmd_done}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    run_cmd(2'b00, 8'h09, 8'hA4, 8'h00, 8'h00, 8'h00, 1'b0, 0);
    repeat (5) @(negedge clk);
    run_cmd(2'b01, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0);
    repeat (5) @(negedge clk);
    run_cmd(2'b10, 8'h00, 8'h00, 8'h82, 8'h04, 8'h02, 1'b0, 0);
    // Issued in the cmd_done cycle of the previous command.
    run_cmd(2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 1'b0, 0);
    repeat (5) @(negedge clk);
    run_cmd(2'b00, 8'h5A, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b1, 0);
    repeat (30) @(negedge clk);
    // Reset lands on data bit 1 (a zero) of the second byte 0x09.
    run_cmd(2'b00, 8'h09, 8'hA4, 8'h00, 8'h00, 8'h00, 1'b0, BYTE_CYC + 1 + 2 * P + 1);
    run_cmd(2'b01, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0);
    repeat (20) @(negedge clk);

    check("cmd_done_pulses", done_pulses, 6);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
